di_load_ctrl: RTL
=================

# di_load_ctrl

Command front-end for the digital clock datapath. It sits directly upstream of the datapath and decodes a stream of ASCII bytes from the console receiver into the datapath's load and run controls: `ld_time`, `ld_alarm`, the one-hot digit strobes, `ld_num`, `dicRun` and `dicSelectLEDdisp`. Time and alarm are entered as four digits in the order MM SS, with per-digit validation and an entry timeout.

## Interface

Parameters:
- IDLE_TIMEOUT, default 10_000_000: clk cycles without an accepted byte before a partially entered time or alarm is abandoned. Must be ≥ 2. The counter width is $clog2(IDLE_TIMEOUT).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle strobe; rx_data is valid. A byte may arrive every cycle and is always accepted.
- rx_data  in  8  ASCII byte
- ld_time  out  1  one-cycle pulse: the current digit strobe loads the clock time
- ld_alarm  out  1  one-cycle pulse: the current digit strobe loads the alarm
- ldMtens, ldMones, ldStens, ldSones  out  1 each  one-hot digit strobe, coincident with ld_time or ld_alarm
- ld_num  out  4  digit value, 0–9
- dicRun  out  1  1 = clock runs
- dicSelectLEDdisp  out  1  one-cycle pulse: advance the LED digit select
- err  out  1  one-cycle pulse on a rejected byte or a timeout

## Operation

States: IDLE, D_MT, D_MO, D_ST, D_SO. A mode register `alm` holds 0 for time entry and 1 for alarm entry. A register `run_sav` holds the saved run flag.

Byte handling in IDLE:
- 'l' or 'L': set alm=0, set run_sav=dicRun, set dicRun=0, go to D_MT.
- 'a' or 'A': set alm=1, go to D_MT. dicRun is unchanged.
- 's' or 'S': set dicRun=0.
- 'g' or 'G': set dicRun=1.
- 'n' or 'N': pulse dicSelectLEDdisp.
- Any other byte: pulse err.

Byte handling in D_xx:
- '0'..'9': set ld_num = rx_data-8'h30. Pulse the state's digit strobe together with ld_time (alm=0) or ld_alarm (alm=1). Advance D_MT→D_MO→D_ST→D_SO→IDLE.
- On leaving D_SO with alm=0: restore dicRun=run_sav.
- ESC (8'h1B): abort.
  - Go to IDLE.
  - Restore dicRun=run_sav if alm=0.
  - Digits already loaded stay loaded.
  - No err pulse.
- Any other byte: pulse err and stay in the same state.

Timeout:
- The counter clears on every rx_valid and in IDLE.
- In D_xx it increments each cycle.
- On reaching IDLE_TIMEOUT-1 it triggers an abort exactly like ESC, plus an err pulse.

Arithmetic: ld_num is the low nibble of (rx_data-8'h30). It is only produced for validated digits.

## Timing

- All outputs are registered.
- Response latency is 1 cycle: a byte with rx_valid at edge N produces its strobes, err, ld_num and dicRun change after edge N+1.
- Strobes are exactly one cycle wide. Back-to-back bytes produce back-to-back strobes.
- ld_num holds its last value between loads.

Reset values: state=IDLE, ld_time=ld_alarm=0, all ld* strobes=0, ld_num=0, dicSelectLEDdisp=0, err=0, dicRun=1, run_sav=1, timeout counter=0.

Boundary rules:
- rst has priority over rx_valid; a byte in the reset cycle is dropped.
- rx_valid in the same cycle as terminal count: the byte wins. The timeout is not taken and the counter clears.
- 'l' or 'a' received while in D_xx is a non-digit: err, no restart.
- Reset during entry: the datapath keeps any digits already loaded. This block returns to IDLE with dicRun=1.

## Configuration

- DI_DIGIT_RANGE_CHECK_EN defined: in D_MT and D_ST, digits '6'..'9' are rejected. The block pulses err, produces no strobe and stays in the same state. D_MO and D_SO accept '0'..'9'.
- DI_DIGIT_RANGE_CHECK_EN undefined: every state accepts '0'..'9'.

## Test plan

- After reset, send "L1234": ld_time+ldMtens with ld_num=1, then ldMones/2, ldStens/3, ldSones/4, each one cycle. dicRun is 0 from after 'L' until after '4', then 1.
- Send "s", then "a0559": ld_alarm strobes load 0,5,5,9. dicRun stays 0 throughout. No ld_time pulse.
- With DI_DIGIT_RANGE_CHECK_EN, send "L7": err pulses, no strobe, state stays D_MT. Then "3" produces ldMtens with ld_num=3. Without the macro, "L7" produces ldMtens with ld_num=7.
- Send "L12" then ESC: two strobes, state returns to IDLE, dicRun=1, no err. Send "x" in IDLE: err=1 for one cycle.
- With IDLE_TIMEOUT=16, send "a5" then idle: err pulses 16 cycles after the '5' strobe, state returns to IDLE. Repeat with a byte arriving on the terminal cycle: no timeout.
- Send "nnnn" on consecutive cycles: dicSelectLEDdisp high for 4 consecutive cycles. Assert rst mid-"L12": all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/di_load_ctrl.sv
// rtl/di_load_ctrl.sv - ASCII console command decoder driving the clock datapath load/run controls
// Optional DI_DIGIT_RANGE_CHECK_EN: reject tens digits '6'..'9' for minutes and seconds.
module di_load_ctrl #(
    parameter int IDLE_TIMEOUT = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       ld_time,
    output logic       ld_alarm,
    output logic       ldMtens,
    output logic       ldMones,
    output logic       ldStens,
    output logic       ldSones,
    output logic [3:0] ld_num,
    output logic       dicRun,
    output logic       dicSelectLEDdisp,
    output logic       err
);

    localparam int CW = $clog2(IDLE_TIMEOUT);
    localparam logic [CW-1:0] TERM = CW'(IDLE_TIMEOUT - 1);
    localparam logic [7:0] ESC = 8'h1B;

    typedef enum logic [2:0] {
        IDLE,
        D_MT,
        D_MO,
        D_ST,
        D_SO
    } state_t;

    state_t        state, stateNxt;
    logic          alm, almNxt;
    logic          runSav, runSavNxt;
    logic          runNxt;
    logic [CW-1:0] cnt, cntNxt;
    logic [3:0]    numNxt;
    logic [3:0]    strbNxt;
    logic          ldTimeNxt, ldAlarmNxt, selNxt, errNxt;
    logic          isDigit, digitOk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            alm              <= 1'b0;
            runSav           <= 1'b1;
            dicRun           <= 1'b1;
            cnt              <= '0;
            ld_num           <= 4'd0;
            ld_time          <= 1'b0;
            ld_alarm         <= 1'b0;
            ldMtens          <= 1'b0;
            ldMones          <= 1'b0;
            ldStens          <= 1'b0;
            ldSones          <= 1'b0;
            dicSelectLEDdisp <= 1'b0;
            err              <= 1'b0;
        end else begin
            state            <= stateNxt;
            alm              <= almNxt;
            runSav           <= runSavNxt;
            dicRun           <= runNxt;
            cnt              <= cntNxt;
            ld_num           <= numNxt;
            ld_time          <= ldTimeNxt;
            ld_alarm         <= ldAlarmNxt;
            {ldMtens, ldMones, ldStens, ldSones} <= strbNxt;
            dicSelectLEDdisp <= selNxt;
            err              <= errNxt;
        end
    end

    always_comb begin
        isDigit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        digitOk = isDigit;
`ifdef DI_DIGIT_RANGE_CHECK_EN
        if ((state == D_MT || state == D_ST) && rx_data > 8'h35) begin
            digitOk = 1'b0;
        end
`endif
    end

    always_comb begin
        stateNxt   = state;
        almNxt     = alm;
        runSavNxt  = runSav;
        runNxt     = dicRun;
        cntNxt     = cnt;
        numNxt     = ld_num;
        strbNxt    = 4'b0000;
        ldTimeNxt  = 1'b0;
        ldAlarmNxt = 1'b0;
        selNxt     = 1'b0;
        errNxt     = 1'b0;

        case (state)
            IDLE: begin
                cntNxt = '0;
                if (rx_valid) begin
                    case (rx_data)
                        8'h6C, 8'h4C: begin
                            almNxt    = 1'b0;
                            runSavNxt = dicRun;
                            runNxt    = 1'b0;
                            stateNxt  = D_MT;
                        end
                        8'h61, 8'h41: begin
                            almNxt   = 1'b1;
                            stateNxt = D_MT;
                        end
                        8'h73, 8'h53: runNxt = 1'b0;
                        8'h67, 8'h47: runNxt = 1'b1;
                        8'h6E, 8'h4E: selNxt = 1'b1;
                        default:      errNxt = 1'b1;
                    endcase
                end
            end
            default: begin
                if (rx_valid) begin
                    cntNxt = '0;
                    if (digitOk) begin
                        // Low nibble of an ASCII digit equals its value
                        numNxt     = rx_data[3:0];
                        ldTimeNxt  = !alm;
                        ldAlarmNxt = alm;
                        case (state)
                            D_MT: begin strbNxt = 4'b1000; stateNxt = D_MO; end
                            D_MO: begin strbNxt = 4'b0100; stateNxt = D_ST; end
                            D_ST: begin strbNxt = 4'b0010; stateNxt = D_SO; end
                            default: begin
                                strbNxt  = 4'b0001;
                                stateNxt = IDLE;
                                if (!alm) runNxt = runSav;
                            end
                        endcase
                    end else if (rx_data == ESC) begin
                        stateNxt = IDLE;
                        if (!alm) runNxt = runSav;
                    end else begin
                        errNxt = 1'b1;
                    end
                end else if (cnt == TERM) begin
                    // Entry abandoned: same as ESC but flagged
                    cntNxt   = '0;
                    stateNxt = IDLE;
                    errNxt   = 1'b1;
                    if (!alm) runNxt = runSav;
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
        endcase
    end

endmodule
